// File: rtl/register_file.sv
// register_file: rv32i architectural integer register file.
// 2^AddrWidth x DataWidth registers. Two combinational read ports and one
// synchronous write port. A per-register pending-load scoreboard reports
// operands that are still waiting on data memory.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle
// write-back to the read ports and busy flags.
// x0 always reads zero and can never be marked pending.
module register_file #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_write,
  input  logic [AddrWidth-1:0] rd_addr,
  input  logic [DataWidth-1:0] rd_data,
  input  logic [AddrWidth-1:0] rs1_addr,
  input  logic [AddrWidth-1:0] rs2_addr,
  output logic [DataWidth-1:0] rs1_data,
  output logic [DataWidth-1:0] rs2_data,
  input  logic                 load_issue,
  input  logic [AddrWidth-1:0] load_rd,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  localparam int NumRegs = 1 << AddrWidth;

  // Register storage is plain flops: every entry must clear asynchronously.
  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [NumRegs-1:0]   pend_q;
  logic [NumRegs-1:0]   pend_d;

  // A write-back to x0 is discarded everywhere.
  logic wb_valid;
  assign wb_valid = reg_write && (rd_addr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NumRegs; gi++) begin : g_reg
      logic wr_en;
      // Entry 0 never sees a write enable, so it holds its reset value of 0.
      assign wr_en = wb_valid && (rd_addr == AddrWidth'(gi)) && (gi != 0);

      // Per-register storage update with asynchronous clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else if (wr_en) begin
          regs_q[gi] <= rd_data;
        end
      end
    end
  endgenerate

  // Scoreboard next state: clear on write-back, then set on load issue so a
  // new load to the same register supersedes the one completing.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid) begin
      pend_d[rd_addr] = 1'b0;
    end
    if (load_issue && (load_rd != '0)) begin
      pend_d[load_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A matching write-back hides the hazard cycle unless a new load to the same
  // register issues in this cycle, in which case the old pending bit is shown.
  logic rs1_hit;
  logic rs2_hit;
  assign rs1_hit = wb_valid && (rs1_addr == rd_addr);
  assign rs2_hit = wb_valid && (rs2_addr == rd_addr);
`endif

  // Read port 1: x0 reads zero, otherwise registered state (or bypass).
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_addr != '0) begin
      rs1_data = regs_q[rs1_addr];
      rs1_busy = pend_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
      if (rs1_hit) begin
        rs1_data = rd_data;
        rs1_busy = (load_issue && (load_rd == rs1_addr)) ? pend_q[rs1_addr] : 1'b0;
      end
`endif
    end
  end

  // Read port 2: identical to port 1, independent address.
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_addr != '0) begin
      rs2_data = regs_q[rs2_addr];
      rs2_busy = pend_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (rs2_hit) begin
        rs2_data = rd_data;
        rs2_busy = (load_issue && (load_rd == rs2_addr)) ? pend_q[rs2_addr] : 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file. Each vector is driven just
// after a falling edge and outputs are checked 1 ns later, i.e. they reflect
// registered state plus any same-cycle inputs, before the next rising edge.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        load_issue = 1'b0;
  logic [4:0]  load_rd = '0;
  logic        rs1_busy;
  logic        rs2_busy;

  int n_vec  = 0;
  int n_fail = 0;

  register_file #(.DataWidth(32), .AddrWidth(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .load_issue (load_issue),
    .load_rd    (load_rd),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        li;
    logic [4:0]  lrd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  function automatic vec_t mk(logic we, logic [4:0] rd, logic [31:0] wd,
                              logic [4:0] a1, logic [4:0] a2,
                              logic li, logic [4:0] lrd,
                              logic [31:0] e1, logic [31:0] e2,
                              logic b1, logic b2);
    vec_t v;
    v.we = we; v.rd = rd; v.wd = wd; v.a1 = a1; v.a2 = a2;
    v.li = li; v.lrd = lrd; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reg_write  = v.we;
    rd_addr    = v.rd;
    rd_data    = v.wd;
    rs1_addr   = v.a1;
    rs2_addr   = v.a2;
    load_issue = v.li;
    load_rd    = v.lrd;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " rs1_data"}, rs1_data, v.e1);
    chk({tag, " rs2_data"}, rs2_data, v.e2);
    chk({tag, " rs1_busy"}, {31'b0, rs1_busy}, {31'b0, v.b1});
    chk({tag, " rs2_busy"}, {31'b0, rs2_busy}, {31'b0, v.b2});
    $display("%s: we=%b rd=%0d wd=%h rs1=%0d rs2=%0d li=%b lrd=%0d -> d1=%h d2=%h b1=%b b2=%b",
             tag, v.we, v.rd, v.wd, v.a1, v.a2, v.li, v.lrd, rs1_data, rs2_data, rs1_busy, rs2_busy);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check_vec(tag, v);
  endtask

  task automatic scan_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("%s rs1_data x%0d", tag, i), rs1_data, 32'h0);
      chk($sformatf("%s rs2_data x%0d", tag, 31 - i), rs2_data, 32'h0);
      chk($sformatf("%s busy x%0d", tag, i), {30'b0, rs1_busy, rs2_busy}, 32'h0);
    end
    $display("%s: scanned 32 registers", tag);
  endtask

  initial begin
    vec_t v;
    //            we rd  wd            a1  a2  li lrd  e1                          e2                          b1         b2
    vt[0]  = mk(0, 0,  32'h0,        0,  31, 0, 0,  32'h0,                      32'h0,                      0,         0);
    vt[1]  = mk(1, 5,  32'hDEADBEEF, 5,  5,  0, 0,  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 0,         0);
    vt[2]  = mk(0, 0,  32'h0,        5,  5,  0, 0,  32'hDEADBEEF,               32'hDEADBEEF,               0,         0);
    vt[3]  = mk(1, 0,  32'h12345678, 0,  0,  0, 0,  32'h0,                      32'h0,                      0,         0);
    vt[4]  = mk(0, 0,  32'h0,        0,  5,  0, 0,  32'h0,                      32'hDEADBEEF,               0,         0);
    vt[5]  = mk(1, 7,  32'hA5A5A5A5, 7,  5,  0, 0,  BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF,               0,         0);
    vt[6]  = mk(0, 0,  32'h0,        7,  7,  0, 0,  32'hA5A5A5A5,               32'hA5A5A5A5,               0,         0);
    vt[7]  = mk(0, 0,  32'h0,        7,  10, 1, 10, 32'hA5A5A5A5,               32'h0,                      0,         0);
    vt[8]  = mk(0, 0,  32'h0,        7,  10, 0, 0,  32'hA5A5A5A5,               32'h0,                      0,         1);
    vt[9]  = mk(1, 10, 32'h0000CAFE, 10, 10, 0, 0,  BYP ? 32'hCAFE : 32'h0,     BYP ? 32'hCAFE : 32'h0,     !BYP,      !BYP);
    vt[10] = mk(0, 0,  32'h0,        10, 10, 0, 0,  32'h0000CAFE,               32'h0000CAFE,               0,         0);
    vt[11] = mk(0, 0,  32'h0,        0,  0,  1, 0,  32'h0,                      32'h0,                      0,         0);
    vt[12] = mk(0, 0,  32'h0,        0,  0,  0, 0,  32'h0,                      32'h0,                      0,         0);
    vt[13] = mk(0, 0,  32'h0,        12, 12, 1, 12, 32'h0,                      32'h0,                      0,         0);
    vt[14] = mk(1, 12, 32'h00000055, 12, 10, 1, 12, BYP ? 32'h55 : 32'h0,       32'h0000CAFE,               1,         0);
    vt[15] = mk(0, 0,  32'h0,        12, 12, 0, 0,  32'h00000055,               32'h00000055,               1,         1);
    vt[16] = mk(1, 12, 32'h00000066, 12, 20, 1, 20, BYP ? 32'h66 : 32'h55,      32'h0,                      !BYP,      0);
    vt[17] = mk(0, 0,  32'h0,        12, 20, 0, 0,  32'h00000066,               32'h0,                      0,         1);
    vt[18] = mk(1, 3,  32'h00000001, 0,  0,  1, 4,  32'h0,                      32'h0,                      0,         0);
    vt[19] = mk(0, 0,  32'h0,        3,  4,  0, 0,  32'h00000001,               32'h0,                      0,         1);

    // Reset held low: every index reads zero and not busy.
    #2;
    scan_all("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    scan_all("reset_released");

    for (int i = 0; i < NV; i++) begin
      apply(vt[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges: x3 and pend[4] are cleared at once.
    #1;
    rst_n = 1'b0;
    #1;
    v = mk(0, 0, 32'h0, 3, 4, 0, 0, 32'h0, 32'h0, 0, 0);
    check_vec("async_reset", v);
    #1;
    rst_n = 1'b1;
    #1;
    check_vec("after_release", v);

    // First write after reset is accepted at the first rising edge.
    apply(mk(1, 3, 32'h00000009, 3, 4, 1, 4, BYP ? 32'h9 : 32'h0, 32'h0, 0, 0), "post_reset_wr");
    apply(mk(0, 0, 32'h0, 3, 4, 0, 0, 32'h9, 32'h0, 0, 1), "post_reset_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
